// File: rtl/sfm_arb_if.sv
// sfm_arb_if: request/grant bundle between the SFM port requesters and
// the SFM arbiter.
//   REQ      - level requests, [3]=TEST [2]=BOOT [1]=PROG [0]=WP
//   ERR_CLR  - single-cycle clear of the sticky timeout flags
//   GNT      - one-hot grant, same bit order as REQ
//   SFM_BUSY - arbiter is anywhere but idle
//   PRG_HOLD - post-program write-time hold-off in progress
//   TIMEOUT  - one-cycle pulse when a grant is reclaimed
//   ERR      - sticky per-requester timeout flags
// master = requester side, slave = arbiter side.
interface sfm_arb_if;
    logic [3:0] REQ;
    logic       ERR_CLR;
    logic [3:0] GNT;
    logic       SFM_BUSY;
    logic       PRG_HOLD;
    logic       TIMEOUT;
    logic [3:0] ERR;

    modport master (
        output REQ, ERR_CLR,
        input  GNT, SFM_BUSY, PRG_HOLD, TIMEOUT, ERR
    );

    modport slave (
        input  REQ, ERR_CLR,
        output GNT, SFM_BUSY, PRG_HOLD, TIMEOUT, ERR
    );
endinterface

// File: rtl/sfm_arb.sv
// sfm_arb: arbiter/sequencer for the single serial flash port.
// Grants one of four requesters at a time (fixed priority TEST > BOOT >
// PROG > WP), enforces a chip-select deselect gap between grants, holds
// off all access after a program for the flash write time, and reclaims
// the port from an owner that holds it longer than TMO_CYC cycles.
// Ports:
//   CLKCMS - system clock, rising edge
//   RST    - synchronous active-high reset
//   sfm    - sfm_arb_if.slave (REQ/ERR_CLR in, GNT/status out)
module sfm_arb #(
    parameter int unsigned GAP_CYC  = 16,     // 1..65535
    parameter int unsigned PRG_WAIT = 4096,   // 0 = no hold-off
    parameter int unsigned TMO_CYC  = 65535   // 0 = no timeout
) (
    input  logic     CLKCMS,
    input  logic     RST,
    sfm_arb_if.slave sfm
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP, HOLD} state_t;

    localparam logic [1:0]  PROG_IDX = 2'd1;
    localparam logic        TMO_EN   = (TMO_CYC != 0);
    localparam logic        HOLD_EN  = (PRG_WAIT != 0);
    // Terminal counts; each counter starts at 0 on entry to its state.
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [15:0] PRG_LAST = 16'(PRG_WAIT - 1);
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  owner_q, owner_d;
    logic        tmo_q, tmo_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] gnt_cnt_q, gnt_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;

    logic [3:0]  elig;
    logic        pick_vld;
    logic [1:0]  pick_idx;
    logic        go_arb;
    logic [3:0]  err_set;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A requester that timed out stays masked until it drops REQ once.
    assign elig = sfm.REQ & ~mask_q;

    always_comb begin
        pick_vld = |elig;
        pick_idx = 2'd0;
        if      (elig[3]) pick_idx = 2'd3;
        else if (elig[2]) pick_idx = 2'd2;
        else if (elig[1]) pick_idx = 2'd1;
        else              pick_idx = 2'd0;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        tmo_d      = 1'b0;
        gnt_cnt_d  = gnt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        err_set    = 4'b0;
        go_arb     = 1'b0;

        case (state_q)
            IDLE: go_arb = 1'b1;

            GRANT: begin
                gnt_cnt_d = sat_inc(gnt_cnt_q);
                if (!sfm.REQ[owner_q]) begin
                    state_d   = GAP;
                    gnt_d     = 4'b0;
                    gap_cnt_d = 16'd0;
                end else if (TMO_EN && gnt_cnt_q == TMO_LAST) begin
                    state_d          = GAP;
                    gnt_d            = 4'b0;
                    gap_cnt_d        = 16'd0;
                    tmo_d            = 1'b1;
                    err_set[owner_q] = 1'b1;
                end
            end

            // owner_q still names the released owner here, so a PROG
            // release (normal or timed out) leads into the hold-off.
            GAP: begin
                gap_cnt_d = sat_inc(gap_cnt_q);
                if (gap_cnt_q == GAP_LAST) begin
                    if (HOLD_EN && owner_q == PROG_IDX) begin
                        state_d    = HOLD;
                        hold_cnt_d = 16'd0;
                    end else begin
                        go_arb = 1'b1;
                    end
                end
            end

            HOLD: begin
                hold_cnt_d = sat_inc(hold_cnt_q);
                if (hold_cnt_q == PRG_LAST) go_arb = 1'b1;
            end

            default: state_d = IDLE;
        endcase

        // Arbitration shared by IDLE and the final GAP/HOLD cycle.
        if (go_arb) begin
            if (pick_vld) begin
                state_d   = GRANT;
                gnt_d     = 4'b0001 << pick_idx;
                owner_d   = pick_idx;
                gnt_cnt_d = 16'd0;
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0;
            end
        end

        // A timeout only fires with REQ high, so set and clear never meet.
        mask_d = (mask_q | err_set) & sfm.REQ;
        // Set beats a same-cycle clear.
        err_d  = (err_q & ~{4{sfm.ERR_CLR}}) | err_set;
    end

    always_ff @(posedge CLKCMS) begin
        if (RST) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0;
            owner_q    <= 2'd0;
            tmo_q      <= 1'b0;
            err_q      <= 4'b0;
            mask_q     <= 4'b0;
            gnt_cnt_q  <= 16'd0;
            gap_cnt_q  <= 16'd0;
            hold_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            mask_q     <= mask_d;
            gnt_cnt_q  <= gnt_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sfm.GNT      = gnt_q;
    assign sfm.SFM_BUSY = (state_q != IDLE);
    assign sfm.PRG_HOLD = (state_q == HOLD);
    assign sfm.TIMEOUT  = tmo_q;
    assign sfm.ERR      = err_q;

endmodule

// File: tb/tb_sfm_arb.sv
// tb_sfm_arb: directed scenarios for sfm_arb plus a randomized run
// compared against a timestamp-based reference model.
module tb_sfm_arb;
    localparam int GAP = 16;
    localparam int PRG = 100;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sfm_arb_if bus ();

    sfm_arb #(.GAP_CYC(GAP), .PRG_WAIT(PRG), .TMO_CYC(TMO)) dut (
        .CLKCMS (clk),
        .RST    (rst),
        .sfm    (bus.slave)
    );

    always #5 clk = ~clk;

    // Step into the next cycle; outputs are settled, inputs may be driven.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.REQ = 4'b0;
        bus.ERR_CLR = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.REQ = 4'b1111;
        bus.ERR_CLR = 1'b0;
        next_cyc();
        next_cyc();
        checks++; if (bus.GNT !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.GNT); end
        checks++; if (bus.SFM_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.SFM_BUSY); end
        checks++; if (bus.PRG_HOLD !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", bus.PRG_HOLD); end
        checks++; if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", bus.TIMEOUT); end
        checks++; if (bus.ERR !== 4'b0) begin errors++; $display("FAIL reset_err: got %b want 0000", bus.ERR); end
        rst = 1'b0;
        bus.REQ = 4'b0;
        next_cyc();
    endtask

    task automatic test_single();
        int zeros;
        do_reset();
        bus.REQ = 4'b0100;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", bus.GNT); end
        repeat (9) next_cyc();
        bus.REQ = 4'b0101;
        repeat (10) next_cyc();
        checks++; if (bus.GNT !== 4'b0100) begin errors++; $display("FAIL single_nopreempt: got %b want 0100", bus.GNT); end
        bus.REQ = 4'b0001;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0000 || bus.SFM_BUSY !== 1'b1) begin
            errors++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/1", bus.GNT, bus.SFM_BUSY); end
        zeros = 0;
        while (bus.GNT === 4'b0 && zeros < 100) begin zeros++; next_cyc(); end
        checks++; if (zeros != GAP) begin errors++; $display("FAIL single_gap: got %0d want %0d", zeros, GAP); end
        checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("FAIL single_next: got %b want 0001", bus.GNT); end
        bus.REQ = 4'b0;
        repeat (GAP + 2) next_cyc();
        checks++; if (bus.SFM_BUSY !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.SFM_BUSY); end
    endtask

    task automatic test_priority();
        logic [3:0] req;
        int cur, zeros, want_zeros;
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        bus.REQ = req;
        next_cyc();
        checks++; if (bus.GNT !== 4'b1000) begin errors++; $display("FAIL prio_first: got %b want 1000", bus.GNT); end
        cur = 3;
        for (int nxt = 2; nxt >= 0; nxt--) begin
            repeat (3) next_cyc();
            req[cur] = 1'b0;
            bus.REQ = req;
            next_cyc();
            zeros = 0;
            while (bus.GNT === 4'b0 && zeros < 400) begin zeros++; next_cyc(); end
            want_zeros = GAP + ((cur == 1) ? PRG : 0);
            want = 4'b0001 << nxt;
            checks++; if (zeros != want_zeros) begin errors++; $display("FAIL prio_gap%0d: got %0d want %0d", nxt, zeros, want_zeros); end
            checks++; if (bus.GNT !== want) begin errors++; $display("FAIL prio_order%0d: got %b want %b", nxt, bus.GNT, want); end
            cur = nxt;
        end
        bus.REQ = 4'b0;
        repeat (GAP + 2) next_cyc();
    endtask

    task automatic test_prog_hold();
        int hold_first, hold_n, gnt_first;
        logic [3:0] gnt_seen;
        do_reset();
        bus.REQ = 4'b0010;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b want 0010", bus.GNT); end
        bus.REQ = 4'b0110;
        repeat (5) next_cyc();
        bus.REQ = 4'b0100;            // release at cycle m
        hold_first = -1; hold_n = 0; gnt_first = -1; gnt_seen = 4'b0;
        for (int k = 1; k <= 200; k++) begin
            next_cyc();
            if (bus.PRG_HOLD === 1'b1) begin
                if (hold_first < 0) hold_first = k;
                hold_n++;
            end
            if (bus.GNT !== 4'b0 && gnt_first < 0) begin
                gnt_first = k;
                gnt_seen = bus.GNT;
                break;
            end
        end
        checks++; if (hold_first != GAP + 1) begin errors++; $display("FAIL hold_start: got %0d want %0d", hold_first, GAP + 1); end
        checks++; if (hold_n != PRG) begin errors++; $display("FAIL hold_len: got %0d want %0d", hold_n, PRG); end
        checks++; if (gnt_first != GAP + 1 + PRG) begin errors++; $display("FAIL hold_regrant: got %0d want %0d", gnt_first, GAP + 1 + PRG); end
        checks++; if (gnt_seen !== 4'b0100) begin errors++; $display("FAIL hold_owner: got %b want 0100", gnt_seen); end
        bus.REQ = 4'b0;
        repeat (GAP + 2) next_cyc();
    endtask

    task automatic test_timeout();
        int k;
        logic regranted;
        do_reset();
        bus.REQ = 4'b0001;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("FAIL tmo_grant: got %b want 0001", bus.GNT); end
        k = 0;
        while (bus.GNT === 4'b0001 && k < 200) begin next_cyc(); k++; end
        checks++; if (k != TMO) begin errors++; $display("FAIL tmo_len: got %0d want %0d", k, TMO); end
        checks++; if (bus.TIMEOUT !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", bus.TIMEOUT); end
        checks++; if (bus.ERR !== 4'b0001) begin errors++; $display("FAIL tmo_err: got %b want 0001", bus.ERR); end
        next_cyc();
        checks++; if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end: got %b want 0", bus.TIMEOUT); end
        regranted = 1'b0;
        repeat (150) begin next_cyc(); if (bus.GNT !== 4'b0) regranted = 1'b1; end
        checks++; if (regranted !== 1'b0) begin errors++; $display("FAIL tmo_masked: got regrant=%b want 0", regranted); end
        bus.REQ = 4'b0;
        bus.ERR_CLR = 1'b1;
        next_cyc();
        bus.ERR_CLR = 1'b0;
        bus.REQ = 4'b0001;
        checks++; if (bus.ERR !== 4'b0) begin errors++; $display("FAIL tmo_errclr: got %b want 0000", bus.ERR); end
        next_cyc();
        checks++; if (bus.GNT !== 4'b0001) begin errors++; $display("FAIL tmo_rearm: got %b want 0001", bus.GNT); end
        repeat (TMO - 1) next_cyc();
        bus.ERR_CLR = 1'b1;           // clear on the same cycle as the set
        next_cyc();
        bus.ERR_CLR = 1'b0;
        checks++; if (bus.ERR !== 4'b0001 || bus.TIMEOUT !== 1'b1) begin
            errors++; $display("FAIL tmo_setwins: got err=%b tmo=%b want 0001/1", bus.ERR, bus.TIMEOUT); end
        bus.REQ = 4'b0;
        repeat (GAP + 2) next_cyc();
    endtask

    task automatic test_reset_midgrant();
        logic held;
        do_reset();
        bus.REQ = 4'b0010;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0010) begin errors++; $display("FAIL rstmid_grant: got %b want 0010", bus.GNT); end
        repeat (3) next_cyc();
        rst = 1'b1;
        bus.REQ = 4'b0100;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0 || bus.SFM_BUSY !== 1'b0 || bus.PRG_HOLD !== 1'b0 || bus.TIMEOUT !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: got gnt=%b busy=%b hold=%b tmo=%b want 0000/0/0/0",
                               bus.GNT, bus.SFM_BUSY, bus.PRG_HOLD, bus.TIMEOUT); end
        rst = 1'b0;
        next_cyc();
        checks++; if (bus.GNT !== 4'b0100) begin errors++; $display("FAIL rstmid_regrant: got %b want 0100", bus.GNT); end
        bus.REQ = 4'b0;
        held = 1'b0;
        repeat (150) begin next_cyc(); if (bus.PRG_HOLD !== 1'b0) held = 1'b1; end
        checks++; if (held !== 1'b0) begin errors++; $display("FAIL rstmid_nohold: got %b want 0", held); end
    endtask

    // Reference model: tracks the current owner and the earliest cycle a
    // new grant may appear, derived from release time plus gap/hold-off.
    task automatic test_random();
        int owner, gstart, free_at, hlo, hhi, pick, nfail;
        logic [3:0] mask, err, req, elig, set, e_gnt;
        logic e_busy, e_hold, e_tmo, clr, r;
        do_reset();
        owner = -1; gstart = 0; free_at = 0; hlo = -1; hhi = -2;
        mask = 4'b0; err = 4'b0; req = 4'b0;
        e_gnt = 4'b0; e_busy = 1'b0; e_hold = 1'b0; e_tmo = 1'b0;
        nfail = 0;
        for (int t = 0; t < 6000; t++) begin
            checks++;
            if (bus.GNT !== e_gnt || bus.SFM_BUSY !== e_busy || bus.PRG_HOLD !== e_hold ||
                bus.TIMEOUT !== e_tmo || bus.ERR !== err) begin
                errors++;
                nfail++;
                if (nfail <= 20)
                    $display("FAIL rand_cyc%0d: got gnt=%b busy=%b hold=%b tmo=%b err=%b want %b/%b/%b/%b/%b",
                             t, bus.GNT, bus.SFM_BUSY, bus.PRG_HOLD, bus.TIMEOUT, bus.ERR,
                             e_gnt, e_busy, e_hold, e_tmo, err);
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 29) == 0) req[i] = ~req[i];
            clr = ($urandom_range(0, 39) == 0);
            r   = ($urandom_range(0, 799) == 0);
            bus.REQ = req;
            bus.ERR_CLR = clr;
            rst = r;

            if (r) begin
                owner = -1; free_at = t + 1; hlo = -1; hhi = -2;
                mask = 4'b0; err = 4'b0; e_tmo = 1'b0;
            end else begin
                set = 4'b0;
                e_tmo = 1'b0;
                elig = req & ~mask;
                if (owner >= 0) begin
                    if (!req[owner] || (t - gstart == TMO - 1)) begin
                        if (req[owner]) begin
                            e_tmo = 1'b1;
                            set[owner] = 1'b1;
                        end
                        free_at = t + 1 + GAP + ((owner == 1) ? PRG : 0);
                        if (owner == 1) begin hlo = t + 1 + GAP; hhi = t + GAP + PRG; end
                        owner = -1;
                    end
                end else if (t + 1 >= free_at && elig != 4'b0) begin
                    pick = -1;
                    for (int i = 3; i >= 0; i--)
                        if (elig[i] && pick < 0) pick = i;
                    owner = pick;
                    gstart = t + 1;
                end
                mask = (mask | set) & req;
                err = (err & ~{4{clr}}) | set;
            end
            e_gnt  = (owner >= 0) ? (4'b0001 << owner) : 4'b0;
            e_busy = (owner >= 0) || (t + 1 < free_at);
            e_hold = (t + 1 >= hlo) && (t + 1 <= hhi);
            next_cyc();
        end
        rst = 1'b0;
        bus.REQ = 4'b0;
        bus.ERR_CLR = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.REQ = 4'b0;
        bus.ERR_CLR = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_prog_hold();
        test_timeout();
        test_reset_midgrant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
